mux3_rr_arbiter: RTL and testbench
==================================

Name: mux3_rr_arbiter

Overview:
Round-robin arbiter that shares one 3-way datapath resource between three requesters. Examples of such a resource are a shared memory port or a writeback path driven through a 3-input select mux. The block grants exactly one requester at a time and drives the 2-bit mux select: 0 = input A / requester 0, 1 = B / requester 1, 2 = C / requester 2. Each grant is held until the resource signals completion, the owner withdraws its request, or a hold-time limit expires.

Parameters:
MAX_HOLD, 16, maximum number of cycles a grant may be held before forced release; legal range is 2..256.
CNT_W, 8, width of the hold counter; must satisfy 2^CNT_W >= MAX_HOLD.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
req  input  3  per-requester request; bit i belongs to requester i and is held high until granted and served.
done  input  1  resource completion strobe for the current owner; ignored when no grant is active.
gnt  output  3  one-hot grant, registered; all zeros when idle.
select  output  2  mux select for the shared path, registered; equals the owner index while busy and holds its last value while idle.
busy  output  1  high while a grant is active.
timeout  output  1  one-cycle pulse, registered, marking a forced release.

Behaviour:
- Reset values: gnt=000, select=00, busy=0, timeout=0, state=IDLE, hold counter=0, last_winner=2. With last_winner=2, requester 0 has first priority after reset.
- States:
  - IDLE: no owner.
  - BUSY: one owner, gnt one-hot.
- IDLE, any req bit high:
  - Search order is last_winner+1, +2, +3 (mod 3); the first set bit wins.
  - Next cycle: state=BUSY, gnt[w]=1, select=w, busy=1, last_winner=w, counter=0.
  - Request-to-grant latency is 1 cycle.
- IDLE, req=000: remain in IDLE; select keeps its previous value.
- BUSY, release conditions (evaluated every cycle, owner w):
  - a) done=1 -> normal release.
  - b) req[w]=0 -> abandon release.
  - c) counter==MAX_HOLD-1 with done=0 and req[w]=1 -> forced release; timeout=1 in the following cycle only.
- On any release, the next cycle has state=IDLE, gnt=000, busy=0; select is unchanged.
- Turnaround: at least one idle cycle between grants. If done is seen at cycle t, gnt drops at t+1 and the next grant can appear no earlier than t+2.
- BUSY with no release condition: gnt and select hold; counter increments by 1.
- Counter: width CNT_W, cleared on grant. It never wraps, because release occurs at MAX_HOLD-1.
- Simultaneous events in the same cycle:
  - done and timeout condition both true: done wins and timeout stays 0.
  - done and req[w]=0: treated as a normal release.
- Requests from non-owners during BUSY are ignored; they are arbitrated in the IDLE cycle after release.
- A requester that was just released, including by timeout, is lowest priority in the next arbitration.
- gnt is always one-hot or zero and never multi-hot. select is always 0, 1 or 2; value 3 is never driven.
- Reset asserted mid-grant: on the next edge all outputs return to their reset values and last_winner=2. Any pending timeout pulse is suppressed.

Test Plan:
- Reset then req=001 at cycle 1 -> gnt=001, select=0, busy=1 at cycle 2. done at cycle 4 -> gnt=000 at cycle 5, select stays 0.
- req=111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,0. Each grant is separated by exactly 1 idle cycle; select tracks 0,1,2,0.
- MAX_HOLD=4, req=010 held, done=0 -> gnt=010 for exactly 4 cycles, then gnt=000 with timeout=1 for one cycle. The next grant to requester 1 follows 1 cycle later when it is the sole requester.
- Owner 2 drops req[2] mid-grant with req=011 pending -> gnt=000 next cycle, then gnt=001 (requester 0 wins after last_winner=2); timeout=0.
- done and counter==MAX_HOLD-1 in the same cycle -> release with timeout=0. done pulsed while idle -> no state change.
- rst asserted while busy with gnt=100 -> next cycle gnt=000, select=0, busy=0. With req=111 applied afterwards, requester 0 is granted first.

Source files
------------

// File: rtl/mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux3_rr_arbiter
// Brief    : Round-robin arbiter for three requesters sharing one 3-way path,
//            driving a registered one-hot grant and a 2-bit mux select.
// Revision : 1.0 - initial release
// ============================================================================
module mux3_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] gnt,
    output logic [1:0] select,
    output logic       busy,
    output logic       timeout
);

    localparam logic [0:0]       c_ST_IDLE   = 1'b0;
    localparam logic [0:0]       c_ST_BUSY   = 1'b1;
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_last, w_last_nxt;
    logic [2:0]       r_gnt, w_gnt_nxt;
    logic [1:0]       r_select, w_select_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [1:0]       w_win;
    logic             w_owner_req;
    logic             w_hold_exp;

    // Search starts just after the previous winner, so it always ends up last.
    always_comb begin
        w_win = 2'd0;
        case (r_last)
            2'd0:    w_win = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    w_win = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: w_win = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign w_owner_req = |(req & r_gnt);
    assign w_hold_exp  = (r_cnt == c_HOLD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_last    <= 2'd2;
            r_gnt     <= 3'b000;
            r_select  <= 2'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_last    <= w_last_nxt;
            r_gnt     <= w_gnt_nxt;
            r_select  <= w_select_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_last_nxt    = r_last;
        w_gnt_nxt     = r_gnt;
        w_select_nxt  = r_select;
        w_timeout_nxt = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (|req) begin
                    w_state_nxt  = c_ST_BUSY;
                    w_cnt_nxt    = '0;
                    w_last_nxt   = w_win;
                    w_gnt_nxt    = 3'b001 << w_win;
                    w_select_nxt = w_win;
                end
            end
            default: begin
                // done takes precedence, so a forced release only flags timeout when it alone fires.
                if (done || !w_owner_req || w_hold_exp) begin
                    w_state_nxt   = c_ST_IDLE;
                    w_gnt_nxt     = 3'b000;
                    w_timeout_nxt = !done && w_owner_req;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        gnt     = r_gnt;
        select  = r_select;
        busy    = (r_state == c_ST_BUSY);
        timeout = r_timeout;
    end

endmodule
`default_nettype wire

// File: tb/tb_mux3_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux3_rr_arbiter
// Brief    : Directed and randomized check of mux3_rr_arbiter against a
//            cycle-level behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux3_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic       done;
    logic [2:0] gnt;
    logic [1:0] select;
    logic       busy;
    logic       timeout;

    int n_vec = 0;
    int n_err = 0;

    // Model state: owner index (-1 when idle) and cycles the owner has held.
    int m_owner = -1;
    int m_last  = 2;
    int m_held  = 0;
    int m_sel   = 0;
    bit m_to    = 1'b0;

    mux3_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .select  (select),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit found;
        int c;
        if (rst) begin
            m_owner = -1; m_last = 2; m_held = 0; m_sel = 0; m_to = 1'b0;
        end else if (m_owner < 0) begin
            m_to  = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                c = (m_last + k) % 3;
                if (!found && req[c]) begin
                    found = 1'b1; m_owner = c; m_last = c; m_sel = c; m_held = 1;
                end
            end
        end else begin
            m_to = !done && req[m_owner] && (m_held == MAX_HOLD);
            if (done || !req[m_owner] || m_held == MAX_HOLD) m_owner = -1;
            else m_held++;
        end
    endtask

    task automatic cycle(input logic [2:0] r, input logic d, input logic rs);
        req = r; done = d; rst = rs;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("gnt",     {29'd0, gnt},    (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        check("select",  {30'd0, select}, 32'(m_sel));
        check("busy",    {31'd0, busy},   {31'd0, m_owner >= 0});
        check("timeout", {31'd0, timeout}, {31'd0, m_to});
    endtask

    initial begin
        req = 3'b000; done = 1'b0; rst = 1'b1;
        cycle(3'b000, 1'b0, 1'b1);
        cycle(3'b000, 1'b0, 1'b1);
        check("reset_gnt", {29'd0, gnt}, 32'd0);
        check("reset_sel", {30'd0, select}, 32'd0);

        // Single request, release on done; select must stay at 0 afterwards.
        cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b001, 1'b1, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        check("sel_hold_idle", {30'd0, select}, 32'd0);

        // All three requesting: expected order 1,2,0,1 from last winner 0.
        for (int i = 0; i < 8; i++) cycle(3'b111, (i % 2) == 1, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);

        // Timeout on a sole requester, then regrant after one idle cycle.
        for (int i = 0; i < 8; i++) cycle(3'b010, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);

        // Owner 2 abandons with 0 and 1 pending.
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b111, 1'b0, 1'b0);
        cycle(3'b011, 1'b0, 1'b0);
        cycle(3'b011, 1'b0, 1'b0);
        cycle(3'b011, 1'b0, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);

        // done coinciding with the hold limit, then done while idle.
        for (int i = 0; i < 5; i++) cycle(3'b100, i == 4, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);

        // Reset in the middle of a grant to requester 2.
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b100, 1'b0, 1'b0);
        cycle(3'b100, 1'b0, 1'b1);
        cycle(3'b111, 1'b0, 1'b0);
        check("post_rst_first", {29'd0, gnt}, 32'd1);
        cycle(3'b000, 1'b0, 1'b0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++)
            cycle(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
